bcd_divider: RTL and testbench



---
 rtl/bcd_divider.sv | 211 +++++++++++++++++++++
 tb/tb_bcd_divider.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_divider.sv
// bcd_divider: converts a 5-digit BCD dividend to binary (one digit per cycle)
// and divides it by an 8-bit binary divisor with a 16-step restoring divider.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   en         - start strobe, accepted in IDLE or DONE
//   bcd_in     - 5 BCD digits, top digit is 3 bits (0-7)
//   Y          - unsigned binary divisor
//   busy       - conversion or division in progress
//   doneSignal - results valid, held until the next accepted start
//   quotient   - unsigned binary quotient
//   remainder  - unsigned binary remainder
//   err        - 00 ok, 01 divide by zero, 10 invalid BCD, 11 dividend > 65535
module bcd_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [18:0] bcd_in,
  input  logic [7:0]  Y,
  output logic        busy,
  output logic        doneSignal,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic [1:0]  err
);

  localparam int unsigned BCD_W = 19;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned Q_W   = 16;
  localparam int unsigned ACC_W = 17;
  localparam int unsigned REM_W = 9;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DIG_W = 4;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_BCD  = 2'b10;
  localparam logic [1:0] ERR_OVF  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DIV_W-1:0]   y_q, y_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [Q_W-1:0]     quo_q, quo_d;
  logic               bad_q, bad_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [Q_W-1:0]     quotient_q, quotient_d;
  logic [DIV_W-1:0]   remainder_q, remainder_d;
  logic [1:0]         err_q, err_d;

  logic [DIG_W-1:0]   digit;
  logic [REM_W-1:0]   shifted;
  logic [REM_W-1:0]   diff;
  logic               fits;
  logic [REM_W-1:0]   rem_nx;

  // Digit selected for the current conversion step, most significant first
  always_comb begin
    digit = '0;
    case (cnt_q)
      4'd0:    digit = {1'b0, bcd_q[18:16]};
      4'd1:    digit = bcd_q[15:12];
      4'd2:    digit = bcd_q[11:8];
      4'd3:    digit = bcd_q[7:4];
      4'd4:    digit = bcd_q[3:0];
      default: digit = '0;
    endcase
  end

  // One restoring-division step; the dividend shifts out of acc MSB first.
  // The partial remainder is always < Y, so its top bit is dropped on shift.
  always_comb begin
    shifted = REM_W'({rem_q, acc_q[15]});
    diff    = shifted - {1'b0, y_q};
    fits    = (shifted >= {1'b0, y_q});
    rem_nx  = fits ? diff : shifted;
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    y_d         = y_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    bad_d       = bad_q;
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (en) begin
          state_d     = S_CONV;
          bcd_d       = bcd_in;
          y_d         = Y;
          cnt_d       = '0;
          acc_d       = '0;
          rem_d       = '0;
          quo_d       = '0;
          bad_d       = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          quotient_d  = '0;
          remainder_d = '0;
          err_d       = ERR_OK;
        end
      end

      S_CONV: begin
        if (y_q == '0) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = '1;
          remainder_d = '0;
          err_d       = ERR_DIV0;
        end else begin
          // acc*10 as shift-and-add
          acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit);
          bad_d = bad_q | (digit > 4'd9);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(4)) begin
            state_d = S_DIV;
            cnt_d   = '0;
          end
        end
      end

      S_DIV: begin
        // Conversion errors are resolved on the first DIV cycle; invalid
        // BCD wins over overflow.
        if (cnt_q == '0 && bad_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = ERR_BCD;
        end else if (cnt_q == '0 && acc_q[16]) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = ERR_OVF;
        end else begin
          acc_d = {1'b0, acc_q[14:0], 1'b0};
          rem_d = rem_nx;
          quo_d = {quo_q[14:0], fits};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(15)) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            quotient_d  = {quo_q[14:0], fits};
            remainder_d = DIV_W'(rem_nx);
            err_d       = ERR_OK;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bcd_q       <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      bad_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      err_q       <= ERR_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      bad_q       <= bad_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      err_q       <= err_d;
    end
  end

  assign busy       = busy_q;
  assign doneSignal = done_q;
  assign quotient   = quotient_q;
  assign remainder  = remainder_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_divider.sv
// Self-checking bench for bcd_divider: directed cases plus randomized
// operations compared with an arithmetic reference model.
module tb_bcd_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [18:0] bcd_in;
  logic [7:0]  Y;
  logic        busy;
  logic        doneSignal;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic [1:0]  err;

  int n_cmp = 0;
  int n_err = 0;

  bcd_divider dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bcd_in     (bcd_in),
    .Y          (Y),
    .busy       (busy),
    .doneSignal (doneSignal),
    .quotient   (quotient),
    .remainder  (remainder),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Decimal value of the BCD word, then the outcome the divider must report
  function automatic void ref_model(input logic [18:0] b, input logic [7:0] y,
                                    output int q, output int r, output int e,
                                    output int lat);
    int  v;
    int  d;
    int  bb;
    bit  bad;
    bb  = int'(b);
    v   = 0;
    bad = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      d = (k == 4) ? ((bb >> 16) & 7) : ((bb >> (4 * k)) & 15);
      if (d > 9) bad = 1'b1;
      v = v * 10 + d;
    end
    if (y == 8'd0) begin
      q = 65535; r = 0; e = 1; lat = 1;
    end else if (bad) begin
      q = 0; r = 0; e = 2; lat = 6;
    end else if (v > 65535) begin
      q = 0; r = 0; e = 3; lat = 6;
    end else begin
      q = v / int'(y); r = v % int'(y); e = 0; lat = 21;
    end
  endfunction

  // Present a start for exactly one rising edge (edge 0)
  task automatic start(input logic [18:0] b, input logic [7:0] y);
    @(negedge clk);
    bcd_in = b;
    Y      = y;
    en     = 1'b1;
    @(negedge clk);
    en     = 1'b0;
  endtask

  // Count edges until doneSignal, bounded; also counts busy samples
  task automatic wait_done(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = 0;
    while (doneSignal !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [18:0] b, input logic [7:0] y);
    int q, r, e, l;
    ref_model(b, y, q, r, e, l);
    chk({tag, ".q"},    int'(quotient),  q);
    chk({tag, ".r"},    int'(remainder), r);
    chk({tag, ".err"},  int'(err),       e);
    chk({tag, ".busy"}, int'(busy),      0);
  endtask

  task automatic run_op(input string tag, input logic [18:0] b, input logic [7:0] y);
    int q, r, e, l, lat, bc;
    ref_model(b, y, q, r, e, l);
    start(b, y);
    wait_done(0, lat, bc);
    chk({tag, ".lat"},   lat, l);
    chk({tag, ".bcyc"},  bc,  l);
    check_result(tag, b, y);
  endtask

  initial begin
    logic [18:0] b;
    logic [7:0]  y;
    int          lat, bc, idx;

    rst = 1'b1; en = 1'b0; bcd_in = '0; Y = '0;
    #3 rst = 1'b0;
    #1;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(doneSignal), 0);
    chk("rst.q",    int'(quotient), 0);
    chk("rst.r",    int'(remainder), 0);
    chk("rst.err",  int'(err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic conversion + division, then hold in DONE
    run_op("v028", 19'h00006, 8'd2);
    repeat (3) @(negedge clk);
    chk("v028.hold.done", int'(doneSignal), 1);
    chk("v028.hold.q",    int'(quotient), 3);

    // Back-to-back from DONE
    run_op("v029a", 19'h00225, 8'd15);
    start(19'h65025, 8'd255);
    chk("v029.clr.done", int'(doneSignal), 0);
    chk("v029.clr.q",    int'(quotient), 0);
    chk("v029.clr.busy", int'(busy), 1);
    wait_done(0, lat, bc);
    chk("v029b.lat", lat, 21);
    check_result("v029b", 19'h65025, 8'd255);

    // Range boundary
    run_op("v030a", 19'h65535, 8'd1);
    run_op("v030b", 19'h65536, 8'd1);

    // Divide by zero, then invalid digit
    run_op("v031a", 19'h12345, 8'd0);
    run_op("v031b", 19'h0000A, 8'd3);
    run_op("v031c", 19'h7A999, 8'd5);

    // en pulse during DIV must be ignored
    start(19'h00100, 8'd7);
    repeat (9) @(negedge clk);
    bcd_in = 19'h00999; Y = 8'd2; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done(10, lat, bc);
    chk("v032.lat", lat, 21);
    check_result("v032", 19'h00100, 8'd7);

    // Reset mid-DIV: outputs clear without a clock edge
    start(19'h54321, 8'd9);
    repeat (11) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("v032.arst.busy", int'(busy), 0);
    chk("v032.arst.done", int'(doneSignal), 0);
    chk("v032.arst.q",    int'(quotient), 0);
    chk("v032.arst.err",  int'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; bcd_in = 19'h00100; Y = 8'd7; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done(0, lat, bc);
    chk("v032.post.lat", lat, 21);
    check_result("v032.post", 19'h00100, 8'd7);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      b[18:16] = 3'($urandom_range(0, 7));
      for (int k = 0; k < 4; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) begin
        idx = int'($urandom_range(0, 3));
        b[4*idx +: 4] = 4'($urandom_range(10, 15));
      end
      y = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op($sformatf("rnd%0d", i), b, y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
